// File: rtl/fmisc_wb_buffer.sv
// Writeback staging FIFO between the FP misc execute lanes and the writeback arbiter.
// Compacts up to IN_NUM results per cycle, presents the oldest OUT_NUM, and squashes redirect-younger entries.
module fmisc_wb_buffer #(
  parameter int IN_NUM     = 2,
  parameter int OUT_NUM    = 1,
  parameter int DEPTH      = 4,
  parameter int ROB_WIDTH  = 5,
  parameter int PREG_WIDTH = 6,
  parameter int XLEN       = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [IN_NUM-1:0]                 in_en,
  input  logic [IN_NUM*(ROB_WIDTH+1)-1:0]   in_robIdx,
  input  logic [IN_NUM*PREG_WIDTH-1:0]      in_rd,
  input  logic [IN_NUM-1:0]                 in_we,
  input  logic [IN_NUM*XLEN-1:0]            in_res,
  input  logic [IN_NUM*5-1:0]               in_exccode,
  output logic                              in_stall,
  output logic [OUT_NUM-1:0]                out_en,
  output logic [OUT_NUM*(ROB_WIDTH+1)-1:0]  out_robIdx,
  output logic [OUT_NUM*PREG_WIDTH-1:0]     out_rd,
  output logic [OUT_NUM-1:0]                out_we,
  output logic [OUT_NUM*XLEN-1:0]           out_res,
  output logic [OUT_NUM*5-1:0]              out_exccode,
  input  logic [OUT_NUM-1:0]                out_valid,
  input  logic                              redirect,
  input  logic [ROB_WIDTH:0]                redirectIdx
);

  localparam int RIW   = ROB_WIDTH + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [RIW-1:0]        robIdx;
    logic [PREG_WIDTH-1:0] rd;
    logic                  we;
    logic [XLEN-1:0]       res;
    logic [4:0]            exc;
  } entry_t;

  entry_t             entries_q [DEPTH];
  entry_t             entries_d [DEPTH];
  logic [DEPTH-1:0]   live_q, live_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [CNT_W-1:0]   enqCnt;
  logic [CNT_W-1:0]   deqCnt;
  logic [PTR_W-1:0]   enqSlot;
  logic [PTR_W-1:0]   portIdx;
  logic               retireRun;
  logic               portRetire;

  // Equal index is not younger, so the redirecting instruction itself survives.
  function automatic logic younger(input logic [RIW-1:0] x, input logic [RIW-1:0] r);
    if (x[RIW-1] == r[RIW-1]) younger = x[RIW-2:0] > r[RIW-2:0];
    else                      younger = x[RIW-2:0] < r[RIW-2:0];
  endfunction

  assign in_stall = (CNT_W'(DEPTH) - count_q) < CNT_W'(IN_NUM);

  // Flush stored entries, then write the compacted lanes; written slots are always free ones.
  always_comb begin
    entries_d = entries_q;
    live_d    = live_q;
    enqCnt    = '0;
    enqSlot   = '0;
    if (redirect) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (younger(entries_q[j].robIdx, redirectIdx)) live_d[j] = 1'b0;
      end
    end
    if (!in_stall) begin
      for (int i = 0; i < IN_NUM; i++) begin
        if (in_en[i]) begin
          enqSlot                   = tail_q + PTR_W'(enqCnt);
          entries_d[enqSlot].robIdx = in_robIdx[i*RIW +: RIW];
          entries_d[enqSlot].rd     = in_rd[i*PREG_WIDTH +: PREG_WIDTH];
          entries_d[enqSlot].we     = in_we[i];
          entries_d[enqSlot].res    = in_res[i*XLEN +: XLEN];
          entries_d[enqSlot].exc    = in_exccode[i*5 +: 5];
          live_d[enqSlot]           = !(redirect && younger(in_robIdx[i*RIW +: RIW], redirectIdx));
          enqCnt                    = enqCnt + CNT_W'(1);
        end
      end
    end
  end

  // Presentation and retirement share the port index; only a leading run of retiring ports pops.
  always_comb begin
    out_en      = '0;
    out_robIdx  = '0;
    out_rd      = '0;
    out_we      = '0;
    out_res     = '0;
    out_exccode = '0;
    deqCnt      = '0;
    retireRun   = 1'b1;
    portIdx     = '0;
    portRetire  = 1'b0;
    for (int k = 0; k < OUT_NUM; k++) begin
      portIdx                       = head_q + PTR_W'(k);
      out_en[k]                     = (count_q > CNT_W'(k)) && live_q[portIdx];
      out_robIdx[k*RIW +: RIW]      = entries_q[portIdx].robIdx;
      out_rd[k*PREG_WIDTH +: PREG_WIDTH] = entries_q[portIdx].rd;
      out_we[k]                     = entries_q[portIdx].we;
      out_res[k*XLEN +: XLEN]       = entries_q[portIdx].res;
      out_exccode[k*5 +: 5]         = entries_q[portIdx].exc;
      portRetire = (count_q > CNT_W'(k)) && ((live_q[portIdx] && out_valid[k]) || !live_q[portIdx]);
      if (retireRun && portRetire) deqCnt = deqCnt + CNT_W'(1);
      else                         retireRun = 1'b0;
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(deqCnt);
    tail_d  = tail_q + PTR_W'(enqCnt);
    count_d = count_q + enqCnt - deqCnt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      live_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      live_q  <= live_d;
    end
  end

  // Payload needs no reset: nothing is presented unless its live bit is set.
  always_ff @(posedge clk) begin
    for (int j = 0; j < DEPTH; j++) begin
      entries_q[j] <= entries_d[j];
    end
  end

endmodule

// File: tb/tb_fmisc_wb_buffer.sv
// Self-checking bench for fmisc_wb_buffer: directed test-plan steps followed by random traffic,
// all compared against a queue-based reference model.
module tb_fmisc_wb_buffer;
  localparam int IN_NUM = 2, OUT_NUM = 1, DEPTH = 4, ROB_WIDTH = 5, PREG_WIDTH = 6, XLEN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  inEn;
  logic [11:0] inRob;
  logic [11:0] inRd;
  logic [1:0]  inWe;
  logic [63:0] inRes;
  logic [9:0]  inExc;
  logic        inStall;
  logic [0:0]  outEn;
  logic [5:0]  outRob;
  logic [5:0]  outRd;
  logic [0:0]  outWe;
  logic [31:0] outRes;
  logic [4:0]  outExc;
  logic [0:0]  outValid;
  logic        redirect;
  logic [5:0]  redirectIdx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  rob;
    logic [5:0]  rd;
    logic        we;
    logic [31:0] res;
    logic [4:0]  exc;
    bit          live;
  } model_t;
  model_t mq[$];

  fmisc_wb_buffer #(
    .IN_NUM(IN_NUM), .OUT_NUM(OUT_NUM), .DEPTH(DEPTH),
    .ROB_WIDTH(ROB_WIDTH), .PREG_WIDTH(PREG_WIDTH), .XLEN(XLEN)
  ) dut (
    .clk(clk), .rst(rst),
    .in_en(inEn), .in_robIdx(inRob), .in_rd(inRd), .in_we(inWe),
    .in_res(inRes), .in_exccode(inExc), .in_stall(inStall),
    .out_en(outEn), .out_robIdx(outRob), .out_rd(outRd), .out_we(outWe),
    .out_res(outRes), .out_exccode(outExc), .out_valid(outValid),
    .redirect(redirect), .redirectIdx(redirectIdx)
  );

  always #5 clk = ~clk;

  // Younger means a forward distance of 1..31 on the 64-entry circular ROB index space.
  function automatic bit youngerRef(input logic [5:0] x, input logic [5:0] r);
    int d;
    d = (int'(x) - int'(r) + 64) % 64;
    return (d > 0) && (d < 32);
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    bit expEn;
    expEn = 1'b0;
    if (mq.size() > 0) expEn = mq[0].live;
    checkVal({tag, ".stall"}, 32'(inStall), 32'((DEPTH - mq.size()) < IN_NUM));
    checkVal({tag, ".en"}, 32'(outEn), 32'(expEn));
    if (expEn) begin
      checkVal({tag, ".rob"}, 32'(outRob), 32'(mq[0].rob));
      checkVal({tag, ".rd"},  32'(outRd),  32'(mq[0].rd));
      checkVal({tag, ".we"},  32'(outWe),  32'(mq[0].we));
      checkVal({tag, ".res"}, outRes,      mq[0].res);
      checkVal({tag, ".exc"}, 32'(outExc), 32'(mq[0].exc));
    end
  endtask

  // Reference update for one edge: retire from the front, flush survivors, then append lanes.
  task automatic modelStep();
    bit stall;
    model_t e;
    stall = (DEPTH - mq.size()) < IN_NUM;
    for (int k = 0; k < OUT_NUM; k++) begin
      if (mq.size() == 0) break;
      if (!mq[0].live || outValid[k]) void'(mq.pop_front());
      else break;
    end
    if (redirect) begin
      foreach (mq[j]) if (youngerRef(mq[j].rob, redirectIdx)) mq[j].live = 1'b0;
    end
    if (!stall) begin
      for (int i = 0; i < IN_NUM; i++) begin
        if (inEn[i]) begin
          e.rob  = inRob[i*6 +: 6];
          e.rd   = inRd[i*6 +: 6];
          e.we   = inWe[i];
          e.res  = inRes[i*32 +: 32];
          e.exc  = inExc[i*5 +: 5];
          e.live = !(redirect && youngerRef(e.rob, redirectIdx));
          mq.push_back(e);
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [1:0] en, input logic [5:0] r0, input logic [5:0] r1,
                               input logic [31:0] res0, input logic [31:0] res1,
                               input logic [5:0] rd0, input logic [5:0] rd1,
                               input logic valid, input logic redir, input logic [5:0] rIdx);
    inEn        = en;
    inRob       = {r1, r0};
    inRd        = {rd1, rd0};
    inRes       = {res1, res0};
    inWe        = 2'($urandom);
    inExc       = 10'($urandom);
    outValid    = valid;
    redirect    = redir;
    redirectIdx = rIdx;
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic cycle(input logic [1:0] en, input logic [5:0] r0, input logic [5:0] r1,
                       input logic valid, input logic redir, input logic [5:0] rIdx);
    applyStimulus(en, r0, r1, $urandom, $urandom, 6'($urandom), 6'($urandom), valid, redir, rIdx);
  endtask

  // Reset is held for one edge with busy inputs to show it overrides everything.
  task automatic doReset();
    inEn        = 2'b11;
    inRob       = 12'($urandom);
    outValid    = 1'b1;
    redirect    = 1'b1;
    redirectIdx = 6'($urandom);
    rst         = 1'b0;
    @(posedge clk);
    mq.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; inEn = '0; inRob = '0; inRd = '0; inWe = '0; inRes = '0; inExc = '0;
    outValid = '0; redirect = 1'b0; redirectIdx = '0;
    repeat (2) @(negedge clk);
    doReset();
    checkVal("reset.en", 32'(outEn), 32'd0);
    checkVal("reset.stall", 32'(inStall), 32'd0);
    checkOutput("reset");

    $display("[TB] single enqueue");
    applyStimulus(2'b01, 6'd3, 6'd0, 32'h3F800000, 32'h0, 6'd5, 6'd0, 1'b0, 1'b0, 6'd0);
    checkOutput("single");
    checkVal("single.en1", 32'(outEn), 32'd1);
    checkVal("single.res", outRes, 32'h3F800000);
    checkVal("single.rd", 32'(outRd), 32'd5);
    checkVal("single.rob", 32'(outRob), 32'd3);
    cycle(2'b00, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0);
    checkVal("single.drained", 32'(outEn), 32'd0);
    checkOutput("single.after");

    $display("[TB] dual enqueue ordering");
    cycle(2'b11, 6'd7, 6'd2, 1'b0, 1'b0, 6'd0);
    checkVal("dual.first", 32'(outRob), 32'd7);
    checkOutput("dual.a");
    cycle(2'b00, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0);
    checkVal("dual.second", 32'(outRob), 32'd2);
    checkOutput("dual.b");
    cycle(2'b00, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0);
    checkOutput("dual.c");

    $display("[TB] fill and stall");
    cycle(2'b11, 6'd10, 6'd11, 1'b0, 1'b0, 6'd0);
    cycle(2'b11, 6'd12, 6'd13, 1'b0, 1'b0, 6'd0);
    checkVal("fill.stall4", 32'(inStall), 32'd1);
    checkOutput("fill.a");
    cycle(2'b11, 6'd14, 6'd15, 1'b0, 1'b0, 6'd0);
    checkVal("fill.ignored", 32'(outRob), 32'd10);
    checkOutput("fill.b");
    cycle(2'b00, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0);
    checkVal("fill.stall3", 32'(inStall), 32'd1);
    checkOutput("fill.c");
    cycle(2'b00, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0);
    checkVal("fill.stall2", 32'(inStall), 32'd0);
    checkOutput("fill.d");
    cycle(2'b00, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0);
    cycle(2'b00, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0);
    cycle(2'b00, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0);
    checkVal("fill.empty", 32'(outEn), 32'd0);
    checkOutput("fill.e");

    $display("[TB] redirect flush");
    cycle(2'b11, 6'd4, 6'd9, 1'b0, 1'b0, 6'd0);
    cycle(2'b01, 6'd6, 6'd0, 1'b0, 1'b0, 6'd0);
    cycle(2'b01, 6'd8, 6'd0, 1'b0, 1'b1, 6'd6);
    checkVal("flush.front4", 32'(outRob), 32'd4);
    checkOutput("flush.a");
    cycle(2'b00, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0);
    checkVal("flush.dead9", 32'(outEn), 32'd0);
    checkOutput("flush.b");
    cycle(2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    checkVal("flush.front6", 32'(outRob), 32'd6);
    checkOutput("flush.c");
    cycle(2'b00, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0);
    checkOutput("flush.d");
    cycle(2'b11, 6'd6, 6'd8, 1'b0, 1'b1, 6'd6);
    checkVal("flush.lane6", 32'(outRob), 32'd6);
    checkOutput("flush.e");
    cycle(2'b00, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0);
    checkVal("flush.lane8", 32'(outEn), 32'd0);
    checkOutput("flush.f");
    cycle(2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    checkOutput("flush.g");

    $display("[TB] wrap-around compare");
    cycle(2'b11, 6'd33, 6'd29, 1'b0, 1'b0, 6'd0);
    cycle(2'b00, 6'd0, 6'd0, 1'b0, 1'b1, 6'd30);
    checkVal("wrap.flushed", 32'(outEn), 32'd0);
    checkOutput("wrap.a");
    cycle(2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0);
    checkVal("wrap.survivor", 32'(outRob), 32'd29);
    checkVal("wrap.survivorEn", 32'(outEn), 32'd1);
    checkOutput("wrap.b");
    cycle(2'b00, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0);
    checkOutput("wrap.c");

    $display("[TB] reset mid-operation");
    cycle(2'b11, 6'd1, 6'd2, 1'b0, 1'b0, 6'd0);
    cycle(2'b01, 6'd3, 6'd0, 1'b0, 1'b0, 6'd0);
    doReset();
    checkVal("midrst.en", 32'(outEn), 32'd0);
    checkVal("midrst.stall", 32'(inStall), 32'd0);
    cycle(2'b01, 6'd20, 6'd0, 1'b0, 1'b0, 6'd0);
    checkVal("midrst.next", 32'(outRob), 32'd20);
    checkOutput("midrst");

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) doReset();
      else cycle(2'($urandom), 6'($urandom), 6'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, 6'($urandom));
      checkOutput("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
